// File: rtl/sd_sector_buf.sv
// rtl/sd_sector_buf.sv - SD sector capture buffer: fills 512 payload bytes plus CRC, then drains to UART TX
module sd_sector_buf #(
  parameter int DATA_BYTES = 512,
  parameter int CRC_BYTES  = 2,
  parameter int TIMEOUT    = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  output logic        sd_ren,
  input  logic        wclk,
  input  logic [7:0]  miso_data,
  output logic        fifo_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] crc_word,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DATA_BYTES);
  localparam int CW = $clog2(DATA_BYTES + CRC_BYTES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CRC_HI   = CW'(DATA_BYTES);
  localparam logic [CW-1:0] LAST_IN  = CW'(DATA_BYTES + CRC_BYTES - 1);
  localparam logic [AW-1:0] LAST_OUT = AW'(DATA_BYTES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic          wclk_s1, wclk_s2;
  logic [7:0]    data_s1;
  logic [CW-1:0] byte_cnt;
  logic [WW-1:0] wdog;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DATA_BYTES];

  logic byte_stb, filling, take, wd_expire, hs;
  assign byte_stb  = wclk_s1 & ~wclk_s2;
  assign filling   = (state == REQ) || (state == FILL);
  assign take      = byte_stb & filling;
  // A byte arriving on the expiry cycle wins over the watchdog.
  assign wd_expire = filling & ~byte_stb & (wdog == WD_LAST);
  assign hs        = tx_valid & tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sd_ren    = 1'b0;
    fifo_busy = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (rd_req) state_nx = REQ;
      REQ: begin
        sd_ren = 1'b1;
        if (byte_stb)       state_nx = FILL;
        else if (wd_expire) state_nx = IDLE;
      end
      FILL: begin
        if (take && byte_cnt == LAST_IN) state_nx = DRAIN;
        else if (wd_expire)              state_nx = IDLE;
      end
      DRAIN: begin
        fifo_busy = 1'b1;
        if (hs && rd_ptr == LAST_OUT) state_nx = DONE;
      end
      DONE: begin
        fifo_busy = 1'b1;
        done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only the data stage aligned with wclk_s1 is ever consumed, so one data flop suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wclk_s1  <= 1'b0;
      wclk_s2  <= 1'b0;
      data_s1  <= 8'h00;
      byte_cnt <= '0;
      wdog     <= '0;
      rd_ptr   <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      crc_word <= 16'h0000;
      err      <= 1'b0;
    end else begin
      wclk_s1 <= wclk;
      wclk_s2 <= wclk_s1;
      data_s1 <= miso_data;
      err     <= wd_expire;
      if (state == IDLE && rd_req) begin
        byte_cnt <= '0;
        wdog     <= '0;
      end
      if (filling) begin
        if (byte_stb) begin
          byte_cnt <= byte_cnt + 1'b1;
          wdog     <= '0;
          if (byte_cnt == CRC_HI)     crc_word[15:8] <= data_s1;
          else if (byte_cnt > CRC_HI) crc_word[7:0]  <= data_s1;
          if (byte_cnt == LAST_IN)    rd_ptr <= '0;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
      // Fetch only while nothing is offered, which yields one bubble per handshake.
      if (state == DRAIN) begin
        if (hs) begin
          tx_valid <= 1'b0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else if (!tx_valid) begin
          tx_data  <= mem[rd_ptr];
          tx_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && byte_cnt < CRC_HI) mem[byte_cnt[AW-1:0]] <= data_s1;
  end
endmodule

// File: tb/tb_sd_sector_buf.sv
// tb/tb_sd_sector_buf.sv - randomized scenario bench for sd_sector_buf against a sector/stream model
module tb_sd_sector_buf;
  logic        clk = 1'b0, rst = 1'b0, rd_req = 1'b0, wclk = 1'b0, tx_ready = 1'b1;
  logic [7:0]  miso_data = 8'h00;
  logic        sd_ren, fifo_busy, tx_valid, done, err;
  logic [7:0]  tx_data;
  logic [15:0] crc_word;

  int total = 0, bad = 0;
  int stable_viol, bubble_viol, hs_cnt, done_cnt, err_cnt, busy_cnt, ren_viol;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0]  exp_mem [512];
  logic [15:0] exp_crc;

  sd_sector_buf #(.DATA_BYTES(512), .CRC_BYTES(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .sd_ren(sd_ren), .wclk(wclk),
    .miso_data(miso_data), .fifo_busy(fifo_busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .crc_word(crc_word),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Protocol observer: samples after tx_ready for the coming edge has settled.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr && !(tx_valid === 1'b1 && tx_data === pd)) stable_viol++;
      if (pv && pr && tx_valid) bubble_viol++;
      if (tx_valid && tx_ready) hs_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (fifo_busy && !done) busy_cnt++;
      if (sd_ren && fifo_busy) ren_viol++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  task clear_mon;
    stable_viol = 0; bubble_viol = 0; hs_cnt = 0; done_cnt = 0;
    err_cnt = 0; busy_cnt = 0; ren_viol = 0;
  endtask

  task start_req;
    @(negedge clk); rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
  endtask

  task send_byte(input logic [7:0] b, input int p);
    @(posedge clk); #1;
    miso_data = b; wclk = 1'b1;
    repeat (p / 2) @(posedge clk);
    #1 wclk = 1'b0;
    repeat (p - p / 2 - 1) @(posedge clk);
  endtask

  task automatic fill_sector(input int pmin, input int pmax, input int nbytes,
                             output logic ren0, output logic ren1);
    logic [7:0] b;
    start_req;
    ren0 = sd_ren;
    ren1 = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      b = (i < 512) ? exp_mem[i] : ((i == 512) ? exp_crc[15:8] : exp_crc[7:0]);
      send_byte(b, int'($urandom_range(pmax, pmin)));
      if (i == 0) begin #1 ren1 = sd_ren; end
    end
  endtask

  task automatic drain(input int stall_idx, input int stall_len, input bit rnd,
                       output int nrx, output int nbad, output int sbad, output int scyc);
    int guard = 0;
    nrx = 0; nbad = 0; sbad = 0; scyc = 0;
    while (nrx < 512 && guard < 40000) begin
      @(negedge clk); #1;
      guard++;
      if (tx_valid && nrx == stall_idx && scyc < stall_len) begin
        if (tx_data !== exp_mem[nrx]) sbad++;
        tx_ready = 1'b0;
        scyc++;
      end else begin
        tx_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        if (tx_valid && tx_ready) begin
          if (tx_data !== exp_mem[nrx]) nbad++;
          nrx++;
        end
      end
    end
  endtask

  task automatic sector_end(output logic d1, output logic b1, output logic d2, output logic b2);
    @(negedge clk); d1 = done; b1 = fifo_busy;
    @(negedge clk); d2 = done; b2 = fifo_busy;
  endtask

  task automatic test_reset;
    logic [28:0] outs;
    #2 rst = 1'b1;
    #1 outs = {sd_ren, fifo_busy, tx_data, tx_valid, crc_word, done, err};
    total++; if (outs !== 29'h0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon;
    send_byte(8'h5A, 6);
    repeat (4) @(posedge clk);
    #1;
    total++; if ({sd_ren, fifo_busy} !== 2'b00) begin bad++; $display("FAIL idle_stb_dropped: got %b want 00", {sd_ren, fifo_busy}); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL idle_no_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_sector;
    logic r0, r1, d1, b1, d2, b2;
    int nrx, nbad, sbad, scyc;
    for (int i = 0; i < 512; i++) exp_mem[i] = i[7:0];
    exp_crc = 16'hABCD;
    clear_mon;
    tx_ready = 1'b1;
    fork
      fill_sector(24, 24, 514, r0, r1);
      drain(-1, 0, 1'b0, nrx, nbad, sbad, scyc);
    join
    sector_end(d1, b1, d2, b2);
    repeat (4) @(negedge clk);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL sec_ren_req: got %b want 1", r0); end
    total++; if (r1 !== 1'b0) begin bad++; $display("FAIL sec_ren_drop: got %b want 0", r1); end
    total++; if (nrx != 512) begin bad++; $display("FAIL sec_rx_count: got %0d want 512", nrx); end
    total++; if (nbad != 0) begin bad++; $display("FAIL sec_payload: got %0d wrong bytes want 0", nbad); end
    total++; if (crc_word !== 16'hABCD) begin bad++; $display("FAIL sec_crc: got %h want abcd", crc_word); end
    total++; if ({d1, b1, d2, b2} !== 4'b1100) begin bad++; $display("FAIL sec_done_pulse: got %b want 1100", {d1, b1, d2, b2}); end
    total++; if (hs_cnt != 512) begin bad++; $display("FAIL sec_handshakes: got %0d want 512", hs_cnt); end
    total++; if (busy_cnt != 1024) begin bad++; $display("FAIL sec_busy_cycles: got %0d want 1024", busy_cnt); end
    total++; if (bubble_viol != 0) begin bad++; $display("FAIL sec_bubble: got %0d want 0", bubble_viol); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL sec_pulses: got done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
  endtask

  task automatic test_stall;
    logic r0, r1, d1, b1, d2, b2;
    int nrx, nbad, sbad, scyc;
    clear_mon;
    tx_ready = 1'b1;
    fork
      fill_sector(24, 24, 514, r0, r1);
      drain(100, 20, 1'b0, nrx, nbad, sbad, scyc);
    join
    sector_end(d1, b1, d2, b2);
    total++; if (scyc != 20 || sbad != 0) begin bad++; $display("FAIL stall_hold: got cycles=%0d wrong=%0d want 20 0", scyc, sbad); end
    total++; if (stable_viol != 0) begin bad++; $display("FAIL stall_stable: got %0d want 0", stable_viol); end
    total++; if (nrx != 512 || nbad != 0) begin bad++; $display("FAIL stall_payload: got rx=%0d wrong=%0d want 512 0", nrx, nbad); end
    total++; if (busy_cnt != 1044) begin bad++; $display("FAIL stall_busy_cycles: got %0d want 1044", busy_cnt); end
    total++; if ({d1, d2} !== 2'b10) begin bad++; $display("FAIL stall_done: got %b want 10", {d1, d2}); end
  endtask

  task automatic test_timeout;
    logic r0;
    int first = -1;
    clear_mon;
    start_req;
    r0 = sd_ren;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (err && first < 0) first = k;
    end
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL to_ren: got %b want 1", r0); end
    total++; if (first != 64) begin bad++; $display("FAIL to_err_cycle: got %0d want 64", first); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL to_err_width: got %0d want 1", err_cnt); end
    total++; if ({sd_ren, fifo_busy, done_cnt != 0} !== 3'b000) begin bad++; $display("FAIL to_idle: got %b want 000", {sd_ren, fifo_busy, done_cnt != 0}); end
  endtask

  task automatic test_wdog_boundary;
    int e0, e1;
    logic s0;
    clear_mon;
    start_req;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 64);
    #1 e0 = err_cnt; s0 = sd_ren;
    repeat (10) @(posedge clk);
    #1 e1 = err_cnt;
    total++; if (e0 != 0 || s0 !== 1'b0) begin bad++; $display("FAIL wd_byte_wins: got err=%0d ren=%b want 0 0", e0, s0); end
    total++; if (e1 != 1) begin bad++; $display("FAIL wd_fill_expire: got %0d want 1", e1); end
    clear_mon;
    start_req;
    send_byte(8'h11, 65);
    send_byte(8'h22, 65);
    repeat (5) @(posedge clk);
    #1;
    total++; if (err_cnt != 1 || fifo_busy !== 1'b0) begin bad++; $display("FAIL wd_gap65: got err=%0d busy=%b want 1 0", err_cnt, fifo_busy); end
  endtask

  task automatic test_drain_ignore;
    logic r0, r1, d1, b1, d2, b2;
    int nrx, nbad, sbad, scyc, ren_after = 0;
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'($urandom);
    exp_crc = 16'($urandom);
    clear_mon;
    fork
      begin
        fill_sector(4, 16, 514, r0, r1);
        start_req;
        for (int i = 0; i < 10; i++) send_byte(8'h55, 6);
      end
      drain(-1, 0, 1'b1, nrx, nbad, sbad, scyc);
    join
    sector_end(d1, b1, d2, b2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sd_ren) ren_after++;
    end
    total++; if (nrx != 512 || nbad != 0) begin bad++; $display("FAIL ign_payload: got rx=%0d wrong=%0d want 512 0", nrx, nbad); end
    total++; if (crc_word !== exp_crc) begin bad++; $display("FAIL ign_crc: got %h want %h", crc_word, exp_crc); end
    total++; if (ren_viol != 0 || ren_after != 0) begin bad++; $display("FAIL ign_no_req: got %0d %0d want 0 0", ren_viol, ren_after); end
    total++; if (done_cnt != 1 || hs_cnt != 512) begin bad++; $display("FAIL ign_done_hs: got %0d %0d want 1 512", done_cnt, hs_cnt); end
    total++; if (stable_viol != 0 || bubble_viol != 0) begin bad++; $display("FAIL ign_protocol: got %0d %0d want 0 0", stable_viol, bubble_viol); end
    total++; if ({d1, b1, d2, b2} !== 4'b1100) begin bad++; $display("FAIL ign_done_pulse: got %b want 1100", {d1, b1, d2, b2}); end
  endtask

  task automatic test_reset_mid_fill;
    logic r0, r1, d1, b1, d2, b2;
    logic [28:0] outs;
    int nrx, nbad, sbad, scyc;
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'($urandom);
    exp_crc = 16'($urandom);
    fill_sector(4, 16, 200, r0, r1);
    @(posedge clk); #1 rst = 1'b1;
    #1 outs = {sd_ren, fifo_busy, tx_data, tx_valid, crc_word, done, err};
    total++; if (outs !== 29'h0) begin bad++; $display("FAIL rst_fill_outs: got %h want 0", outs); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon;
    repeat (80) @(negedge clk);
    total++; if (done_cnt != 0 || err_cnt != 0) begin bad++; $display("FAIL rst_no_stale: got done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'($urandom);
    exp_crc = 16'($urandom);
    tx_ready = 1'b1;
    fork
      fill_sector(4, 16, 514, r0, r1);
      drain(-1, 0, 1'b0, nrx, nbad, sbad, scyc);
    join
    sector_end(d1, b1, d2, b2);
    total++; if (nrx != 512 || nbad != 0) begin bad++; $display("FAIL rst_new_payload: got rx=%0d wrong=%0d want 512 0", nrx, nbad); end
    total++; if (crc_word !== exp_crc) begin bad++; $display("FAIL rst_new_crc: got %h want %h", crc_word, exp_crc); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL rst_new_pulses: got done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
  endtask

  initial begin
    clear_mon;
    test_reset;
    test_sector;
    test_stall;
    test_timeout;
    test_wdog_boundary;
    test_drain_ignore;
    test_reset_mid_fill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
